// File: rtl/tx_pkg.sv
// -----------------------------------------------------------------------------
// tx_pkg : shared definitions for the tx_symbol_gen I/Q symbol source.
//   - mode_e          : modulation select encodings
//   - prbs_tap()      : lower feedback tap for a supported LFSR order
//   - qam_gray_level(): Gray-coded 16-QAM level (-3,-1,+1,+3) for a bit pair
// -----------------------------------------------------------------------------
package tx_pkg;

  typedef enum logic {
    MODE_QPSK  = 1'b0,
    MODE_QAM16 = 1'b1
  } mode_e;

  // Lower tap T of x^N + x^T + 1. Unsupported orders return N-1 only so that
  // indexing stays legal; the top flags them at elaboration.
  function automatic int prbs_tap(input int order);
    case (order)
      7:       return 6;
      9:       return 5;
      15:      return 14;
      default: return order - 1;
    endcase
  endfunction

  // Per-branch Gray map: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3
  function automatic logic signed [2:0] qam_gray_level(input logic b_first,
                                                        input logic b_second);
    case ({b_first, b_second})
      2'b00:   return -3'sd3;
      2'b01:   return -3'sd1;
      2'b11:   return 3'sd1;
      default: return 3'sd3;
    endcase
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// -----------------------------------------------------------------------------
// prbs_lfsr : Fibonacci LFSR, order ORDER, advancing one or two steps per
// enabled clock. The two bits that would be shifted out next are exposed as a
// lookahead so the mapper can use them in the same cycle the register advances.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (loads seed)
//   adv        : advance this cycle
//   step2      : 1 = advance two steps, 0 = one step
//   look[1:0]  : {first bit out, second bit out}
// -----------------------------------------------------------------------------
module prbs_lfsr
  import tx_pkg::*;
#(
  parameter int               ORDER = 9,
  parameter logic [ORDER-1:0] SEED  = '1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,
  input  logic       step2,
  output logic [1:0] look
);

  localparam int TAP = prbs_tap(ORDER);
  // An all-zero state would lock up the register.
  localparam logic [ORDER-1:0] SEED_EFF = (SEED == '0) ? '1 : SEED;

  logic [ORDER-1:0] s_q, s_d;

  function automatic logic [ORDER-1:0] lfsr_next(input logic [ORDER-1:0] s);
    return {s[ORDER-2:0], s[ORDER-1] ^ s[TAP-1]};
  endfunction

  always_comb begin
    s_d = s_q;
    if (adv) s_d = step2 ? lfsr_next(lfsr_next(s_q)) : lfsr_next(s_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_q <= SEED_EFF;
    else        s_q <= s_d;
  end

  // The second bit out is the current s[N-2], since one shift moves it to MSB.
  assign look = s_q[ORDER-1 -: 2];

endmodule

// File: rtl/tx_symbol_gen.sv
// -----------------------------------------------------------------------------
// tx_symbol_gen : PRBS-driven QPSK / 16-QAM I/Q sample source with integer
// oversampling (zero-stuff or hold) and a registered valid/ready output.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   en            : generation enable
//   mode          : 0 = QPSK, 1 = 16-QAM, taken at symbol boundaries only
//   tx_ready      : downstream accepts the presented sample
//   tx_valid      : tx_i/tx_q hold a valid sample
//   tx_i, tx_q    : signed I/Q samples
//   sym_start     : presented sample is phase 0 of a symbol
//   sym_cnt       : index of the presented symbol (wraps)
// -----------------------------------------------------------------------------
module tx_symbol_gen
  import tx_pkg::*;
#(
  parameter int                    DATA_WIDTH = 20,
  parameter int                    PRBS_ORDER = 9,
  parameter logic [PRBS_ORDER-1:0] SEED_I     = 9'h1AA,
  parameter logic [PRBS_ORDER-1:0] SEED_Q     = 9'h1FE,
  parameter int                    AMP_QPSK   = 131072,
  parameter int                    AMP_QAM    = 43690,
  parameter int                    OSF        = 4,
  parameter bit                    ZERO_STUFF = 1'b1,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         mode,
  input  logic                         tx_ready,
  output logic                         tx_valid,
  output logic signed [DATA_WIDTH-1:0] tx_i,
  output logic signed [DATA_WIDTH-1:0] tx_q,
  output logic                         sym_start,
  output logic [CNT_WIDTH-1:0]         sym_cnt
);

  if (!(PRBS_ORDER == 7 || PRBS_ORDER == 9 || PRBS_ORDER == 15)) begin : g_bad_order
    $error("tx_symbol_gen: PRBS_ORDER must be 7, 9 or 15");
  end
  if (OSF < 1) begin : g_bad_osf
    $error("tx_symbol_gen: OSF must be at least 1");
  end
  if (3 * AMP_QAM >= 2 ** (DATA_WIDTH - 1) || AMP_QPSK >= 2 ** (DATA_WIDTH - 1)) begin : g_bad_amp
    $error("tx_symbol_gen: level constants do not fit DATA_WIDTH");
  end

  localparam int               PH_W    = (OSF > 1) ? $clog2(OSF) : 1;
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(OSF - 1);

  // All levels are elaboration-time constants; the mapper is a pure mux.
  localparam logic signed [DATA_WIDTH-1:0] QPSK_P = DATA_WIDTH'(AMP_QPSK);
  localparam logic signed [DATA_WIDTH-1:0] QPSK_N = DATA_WIDTH'(-AMP_QPSK);
  localparam logic signed [DATA_WIDTH-1:0] QAM_P1 = DATA_WIDTH'(AMP_QAM);
  localparam logic signed [DATA_WIDTH-1:0] QAM_N1 = DATA_WIDTH'(-AMP_QAM);
  localparam logic signed [DATA_WIDTH-1:0] QAM_P3 = DATA_WIDTH'(3 * AMP_QAM);
  localparam logic signed [DATA_WIDTH-1:0] QAM_N3 = DATA_WIDTH'(-3 * AMP_QAM);

  function automatic logic signed [DATA_WIDTH-1:0] map_qpsk(input logic b);
    return b ? QPSK_N : QPSK_P;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] map_qam(input logic [1:0] bits);
    case (qam_gray_level(bits[1], bits[0]))
      -3'sd3:  return QAM_N3;
      -3'sd1:  return QAM_N1;
      3'sd1:   return QAM_P1;
      default: return QAM_P3;
    endcase
  endfunction

  logic                         tx_valid_q, tx_valid_d;
  logic signed [DATA_WIDTH-1:0] tx_i_q, tx_i_d, tx_q_q, tx_q_d;
  logic                         sym_start_q, sym_start_d;
  logic [CNT_WIDTH-1:0]         sym_cnt_q, sym_cnt_d, nxt_cnt_q, nxt_cnt_d;
  logic [PH_W-1:0]              phase_q, phase_d;
  mode_e                        mode_q, mode_d;
  logic                         load, boundary, qam_now;
  logic [1:0]                   look_i, look_q;

  // A held sample is only replaced once it has been accepted.
  assign load     = en && (!tx_valid_q || tx_ready);
  assign boundary = load && (phase_q == '0);
  assign qam_now  = (mode_e'(mode) == MODE_QAM16);

  prbs_lfsr #(.ORDER(PRBS_ORDER), .SEED(SEED_I)) u_lfsr_i (
    .clk(clk), .rst_n(rst_n), .adv(boundary), .step2(qam_now), .look(look_i)
  );

  prbs_lfsr #(.ORDER(PRBS_ORDER), .SEED(SEED_Q)) u_lfsr_q (
    .clk(clk), .rst_n(rst_n), .adv(boundary), .step2(qam_now), .look(look_q)
  );

  always_comb begin
    tx_valid_d  = tx_valid_q;
    tx_i_d      = tx_i_q;
    tx_q_d      = tx_q_q;
    sym_start_d = sym_start_q;
    sym_cnt_d   = sym_cnt_q;
    nxt_cnt_d   = nxt_cnt_q;
    phase_d     = phase_q;
    mode_d      = mode_q;
    if (load) begin
      tx_valid_d = 1'b1;
      phase_d    = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      if (phase_q == '0) begin
        mode_d      = mode_e'(mode);
        sym_start_d = 1'b1;
        sym_cnt_d   = nxt_cnt_q;
        nxt_cnt_d   = nxt_cnt_q + 1'b1;
        if (qam_now) begin
          tx_i_d = map_qam(look_i);
          tx_q_d = map_qam(look_q);
        end else begin
          tx_i_d = map_qpsk(look_i[1]);
          tx_q_d = map_qpsk(look_q[1]);
        end
      end else begin
        sym_start_d = 1'b0;
        // Hold mode simply keeps the symbol already in the output register.
        if (ZERO_STUFF) begin
          tx_i_d = '0;
          tx_q_d = '0;
        end
      end
    end else if (tx_ready) begin
      // Not loading but accepted: en is low, so the output drains.
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_q  <= 1'b0;
      tx_i_q      <= '0;
      tx_q_q      <= '0;
      sym_start_q <= 1'b0;
      sym_cnt_q   <= '0;
      nxt_cnt_q   <= '0;
      phase_q     <= '0;
      mode_q      <= MODE_QPSK;
    end else begin
      tx_valid_q  <= tx_valid_d;
      tx_i_q      <= tx_i_d;
      tx_q_q      <= tx_q_d;
      sym_start_q <= sym_start_d;
      sym_cnt_q   <= sym_cnt_d;
      nxt_cnt_q   <= nxt_cnt_d;
      phase_q     <= phase_d;
      mode_q      <= mode_d;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_i      = tx_i_q;
  assign tx_q      = tx_q_q;
  assign sym_start = sym_start_q;
  assign sym_cnt   = sym_cnt_q;

endmodule

// File: tb/tb_tx_symbol_gen.sv
// -----------------------------------------------------------------------------
// tb_tx_symbol_gen : directed bench for tx_symbol_gen. Three instances share
// the same stimulus: OSF=1, OSF=4 zero-stuffed (4-bit sym_cnt) and OSF=4 hold.
// Expected PRBS9 bits are written out by hand from the seeds:
//   I seed 1AA -> a[n], Q seed 1FE -> b[n], with x[n+9] = x[n] ^ x[n+4].
// -----------------------------------------------------------------------------
module tb_tx_symbol_gen;

  localparam int A  = 131072;
  localparam int U  = 43690;
  localparam int U3 = 131070;

  logic clk = 1'b0;
  logic rst_n, en, mode, tx_ready;

  logic                v1, v4z, v4h, s1, s4z, s4h;
  logic signed [19:0]  i1, q1, i4z, q4z, i4h, q4h;
  logic [15:0]         c1, c4h;
  logic [3:0]          c4z;

  int npass = 0;
  int ntot  = 0;

  //                   0 1 2 3 4 5 6 7 8 9 10 11 12 13 14 15 16 17 18 19
  bit a [20] = '{1,1,0,1,0,1,0,1,0,1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
  bit b [16] = '{1,1,1,1,1,1,1,1,0,0, 0, 0, 0, 1, 1, 1};

  // Mode-toggle window k=16..24 for the OSF=4 instances
  int tz [9] = '{A, 0, 0, 0, U3, 0, 0, 0, -A};
  int th [9] = '{A, A, A, A, U3, U3, U3, U3, -A};

  always #5 clk = ~clk;

  tx_symbol_gen #(.OSF(1), .ZERO_STUFF(1'b1), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .tx_ready(tx_ready),
    .tx_valid(v1), .tx_i(i1), .tx_q(q1), .sym_start(s1), .sym_cnt(c1)
  );

  tx_symbol_gen #(.OSF(4), .ZERO_STUFF(1'b1), .CNT_WIDTH(4)) dut4z (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .tx_ready(tx_ready),
    .tx_valid(v4z), .tx_i(i4z), .tx_q(q4z), .sym_start(s4z), .sym_cnt(c4z)
  );

  tx_symbol_gen #(.OSF(4), .ZERO_STUFF(1'b0), .CNT_WIDTH(16)) dut4h (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .tx_ready(tx_ready),
    .tx_valid(v4h), .tx_i(i4h), .tx_q(q4h), .sym_start(s4h), .sym_cnt(c4h)
  );

  function automatic int qp(input bit x);
    return x ? -A : A;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_osf4(input int k, input int exp_z, input int exp_h,
                          input bit start, input int cnt);
    chk($sformatf("z_i k%0d", k), i4z, exp_z);
    chk($sformatf("z_start k%0d", k), s4z, start);
    chk($sformatf("z_cnt k%0d", k), c4z, cnt);
    chk($sformatf("h_i k%0d", k), i4h, exp_h);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; tx_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_valid1", v1, 0);
    chk("rst_i1", i1, 0);
    chk("rst_q1", q1, 0);
    chk("rst_start1", s1, 0);
    chk("rst_cnt1", c1, 0);
    chk("rst_validz", v4z, 0);

    rst_n = 1'b1;
    tick();
    chk("idle_valid1", v1, 0);
    chk("idle_valid4", v4z, 0);

    // QPSK stream, with a 5-cycle stall after sample 8
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("valid1 k%0d", k), v1, 1);
      chk($sformatf("i1 k%0d", k), i1, qp(a[k]));
      chk($sformatf("q1 k%0d", k), q1, qp(b[k]));
      chk($sformatf("start1 k%0d", k), s1, 1);
      chk($sformatf("cnt1 k%0d", k), c1, k);
      chk_osf4(k, (k % 4 == 0) ? qp(a[k/4]) : 0, qp(a[k/4]), (k % 4 == 0), k / 4);
      if (k == 8) begin
        tx_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          tick();
          chk($sformatf("hold_valid1 j%0d", j), v1, 1);
          chk($sformatf("hold_i1 j%0d", j), i1, A);
          chk($sformatf("hold_cnt1 j%0d", j), c1, 8);
          chk_osf4(100 + j, A, A, 1'b1, 2);
          if (j == 1) en = 1'b0;
          if (j == 3) en = 1'b1;
        end
        tx_ready = 1'b1;
      end
    end

    // Mode toggles at phase 2 only take effect at the following boundary
    for (int k = 16; k <= 24; k++) begin
      tick();
      chk_osf4(k, tz[k-16], th[k-16], (k % 4 == 0), k / 4);
      if (k == 17) mode = 1'b1;
      if (k == 21) mode = 1'b0;
    end

    // Asynchronous reset in the middle of a symbol
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid1", v1, 0);
    chk("arst_i1", i1, 0);
    chk("arst_q1", q1, 0);
    chk("arst_validz", v4z, 0);
    chk("arst_iz", i4z, 0);
    chk("arst_ih", i4h, 0);
    chk("arst_cntz", c4z, 0);
    chk("arst_starth", s4h, 0);

    // 16-QAM from the seed
    mode = 1'b1;
    tick();
    rst_n = 1'b1;
    begin
      int qi [4] = '{U, -U, -U, -U};
      for (int k = 0; k < 4; k++) begin
        tick();
        chk($sformatf("qam_i1 k%0d", k), i1, qi[k]);
        chk($sformatf("qam_q1 k%0d", k), q1, U);
        chk($sformatf("qam_cnt1 k%0d", k), c1, k);
        chk($sformatf("qam_iz k%0d", k), i4z, (k == 0) ? U : 0);
      end
    end

    // Full PRBS9 period in QPSK: 511 symbols = 2044 samples at OSF=4
    rst_n = 1'b0;
    mode  = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k <= 2052; k++) begin
      tick();
      if (k == 0)    chk("per_i1 k0", i1, -A);
      if (k >= 2044 && k <= 2052) begin
        chk($sformatf("per_i1 k%0d", k), i1, qp(a[k-2044]));
        chk($sformatf("per_cnt1 k%0d", k), c1, k);
      end
      if (k == 2040) chk("wrap_cntz k2040", c4z, 14);
      if (k == 2044) begin
        chk("per_iz k2044", i4z, -A);
        chk("per_startz k2044", s4z, 1);
        chk("wrap_cntz k2044", c4z, 15);
      end
      if (k == 2046) chk("per_ih k2046", i4h, -A);
      if (k == 2048) begin
        chk("per_iz k2048", i4z, -A);
        chk("wrap_cntz k2048", c4z, 0);
      end
      if (k == 2052) begin
        chk("per_iz k2052", i4z, A);
        chk("wrap_cntz k2052", c4z, 1);
      end
    end

    // en low with the sample accepted drains tx_valid
    en = 1'b0;
    tick();
    chk("drain_valid1", v1, 0);
    chk("drain_validz", v4z, 0);
    chk("drain_validh", v4h, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/tx_symbol_gen.md
Name: tx_symbol_gen

Overview:
Parametrised I/Q symbol source and the next generation of the team's QPSK transmitter front end.
- Two independent Fibonacci LFSRs (I and Q branches) of selectable order.
- Runtime QPSK / 16-QAM (Gray) mapping.
- Integer oversampling by hold or zero-stuffing.
- Registered valid/ready output toward the pulse-shaping filter, with a free-running symbol counter for BER alignment.

Parameters:
- DATA_WIDTH, 20, signed width of tx_i/tx_q.
- PRBS_ORDER, 9, LFSR order; legal values 7, 9, 15; any other value is a $error at elaboration.
- SEED_I, 9'h1AA, I-branch LFSR seed (PRBS_ORDER bits); an all-zero seed is replaced by all-ones.
- SEED_Q, 9'h1FE, Q-branch LFSR seed; same zero rule as SEED_I.
- AMP_QPSK, 131072, QPSK level magnitude.
- AMP_QAM, 43690, 16-QAM unit level; outer level = 3*AMP_QAM and must fit DATA_WIDTH.
- OSF, 4, samples per symbol, ≥1.
- ZERO_STUFF, 1, 1 = samples 1..OSF-1 are zero; 0 = symbol held for OSF samples.
- CNT_WIDTH, 16, width of sym_cnt.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, generation enable.
- mode, in, 1, 0 = QPSK, 1 = 16-QAM; sampled only at symbol boundaries.
- tx_ready, in, 1, downstream accepts sample.
- tx_valid, out, 1, tx_i/tx_q hold a valid sample.
- tx_i, out, DATA_WIDTH signed, in-phase sample.
- tx_q, out, DATA_WIDTH signed, quadrature sample.
- sym_start, out, 1, current sample is phase 0 of a symbol.
- sym_cnt, out, CNT_WIDTH, index of the symbol currently presented; wraps.

Behaviour:
- Reset (async assert, sync release): tx_valid=0, tx_i=tx_q=0, sym_start=0, sym_cnt=0, phase=0, LFSRs=seeds, latched mode=0.
- LFSR taps:
  - PRBS7: x^7+x^6+1.
  - PRBS9: x^9+x^5+1.
  - PRBS15: x^15+x^14+1.
- LFSR step: out_bit = s[N-1]; s <= {s[N-2:0], s[N-1]^s[T-1]}, where T is the lower tap. Period is 2^N-1 bits.
- load = en && (!tx_valid || tx_ready). Output registers update only on load.
- Once tx_valid=1, tx_i/tx_q/sym_start/sym_cnt stay stable until accepted (tx_valid && tx_ready), independent of en.
- If en=0 and the sample is accepted, tx_valid falls to 0 the next cycle.
- Latency: first valid sample appears 1 cycle after the first cycle with en=1 out of reset. Full-throughput with tx_ready=1: one sample per clock.
- Symbol boundary = load with phase==0. At a boundary:
  - mode is latched.
  - Each LFSR advances 1 step (QPSK) or 2 steps (16-QAM), all in one clock.
  - The new symbol is mapped.
  - sym_start=1.
  - sym_cnt increments (wraps 2^CNT_WIDTH-1→0). The first symbol after reset carries sym_cnt=0.
- Non-boundary loads (phase 1..OSF-1):
  - LFSRs and mode are unchanged; sym_start=0.
  - Output is 0 if ZERO_STUFF=1, otherwise the held symbol.
- phase increments on each load and wraps OSF-1→0. With OSF=1 every load is a boundary.
- QPSK mapping: bit 0 → +AMP_QPSK, bit 1 → −AMP_QPSK.
- 16-QAM mapping, per branch, bits (b_first, b_second): 00→−3U, 01→−U, 11→+U, 10→+3U, with U=AMP_QAM.
- Level constants are computed at DATA_WIDTH width; no runtime multiplier.
- A mode change mid-symbol takes effect at the next boundary only.
- Reset mid-operation: the outputs drop to reset values immediately, with no partial symbol retained.

Decomposition:
- Package tx_pkg holds:
  - mode encodings (MODE_QPSK=0, MODE_QAM16=1);
  - the tap-position function of PRBS_ORDER;
  - the 16-QAM Gray level function.
- One sub-module, prbs_lfsr: parametrised order/seed, with a step1/step2 advance input and a 2-bit lookahead output. It is instantiated twice, once per branch.
- Mapper, phase counter and output register stay in the top.

Test Plan:
1. Reset release, en=1, tx_ready=1, QPSK, OSF=1: I samples in order are −A,−A,+A,−A,+A,−A,+A,−A,+A (A=131072); first Q sample is −A; tx_valid rises 1 cycle after en.
2. mode=1, OSF=1: I bit pairs (1,1),(0,1),(0,1),(0,1) give +43690, −43690, −43690, −43690; sym_cnt = 0,1,2,3.
3. OSF=4, ZERO_STUFF=1, QPSK: I = −A,0,0,0,−A,0,0,0; sym_start pattern 1,0,0,0,1,0,0,0. With ZERO_STUFF=0, I = −A ×4, then −A ×4.
4. Backpressure: tx_ready low for 5 cycles mid-stream → outputs and sym_cnt frozen and the LFSR does not advance; the sequence resumes with no skipped or repeated sample.
5. Toggle mode at phase 2 with OSF=4 → the current symbol completes in the old mode, and the next boundary uses the new mode. Over 511×OSF QPSK samples with PRBS9, the I sequence repeats exactly, and sym_cnt wraps correctly when CNT_WIDTH=4.
6. Assert rst_n low mid-symbol while tx_valid=1 → tx_valid, tx_i and tx_q are 0 in the same cycle (async); after release, the sequence restarts from the seed.
